shift_unit_ctrl: RTL and testbench
==================================

# shift_unit_ctrl

Two-stage pipelined control wrapper around the 32-bit barrel shifter in the execute path. It accepts MIPS shift requests (funct, shamt, rs/rt operands) over a valid/ready handshake and decodes them into the shifter's `a`/`b`/`aluc` inputs from a registered stage. It then captures the shifter's combinational result into an output register with its own valid/ready handshake. It also flags and counts illegal funct codes.

## Interface
- No parameters; all widths fixed.
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; discards both pipeline stages
- in_valid  in  1  request present
- in_ready  out  1  request accepted on edge where in_valid && in_ready
- funct  in  6  MIPS R-type funct field
- shamt  in  5  immediate shift amount
- rs_data  in  32  variable shift amount source (bits [4:0] used)
- rt_data  in  32  value to shift
- sh_a  out  32  to shifter `a`
- sh_b  out  5  to shifter `b`
- sh_aluc  out  2  to shifter `aluc` (00 sra, 01 srl, 10 sll)
- sh_c  in  32  shifter result, combinational from sh_a/sh_b/sh_aluc
- out_valid  out  1  result present
- out_ready  in  1  result consumed on edge where out_valid && out_ready
- out_data  out  32  shifted result
- out_err  out  1  result came from illegal funct
- err_cnt  out  8  saturating count of illegal requests completed

## Operation
- Decode at acceptance: sll 0x00 (aluc 10, b=shamt); srl 0x02 (01, shamt); sra 0x03 (00, shamt); sllv 0x04 (10, rs_data[4:0]); srlv 0x06 (01, rs_data[4:0]); srav 0x07 (00, rs_data[4:0]). sh_a always = rt_data.
- Any other funct: stage-1 err bit set, sh_a=0, sh_b=0, sh_aluc=01; output stage then loads out_data=0, out_err=1.
- Stage 1 (s1_valid, a, b, aluc, err) drives sh_* directly from registers; no combinational path from in_* to sh_*.
- Advance: s2_free = !out_valid || out_ready; s1 moves to output stage when s1_valid && s2_free, capturing sh_c (or 0 if err) into out_data.
- in_ready = !flush && (!s1_valid || s2_free). Combinational; depends on out_ready.
- Stage 1 loads on accept; clears s1_valid when it advances without a new accept.
- err_cnt increments by 1 when an err result is loaded into the output stage; saturates at 255; cleared only by reset (not by flush).
- flush: on that edge s1_valid←0, out_valid←0, nothing accepted, nothing loaded; err_cnt unchanged.

## Timing
- Reset (async, immediate): s1_valid=0, out_valid=0, out_data=0, out_err=0, err_cnt=0, sh_a=0, sh_b=0, sh_aluc=01. in_ready=1 after reset deasserts (flush low).
- Latency: request accepted at edge N → out_valid=1 with result after edge N+1 (visible in cycle N+1 to N+2, i.e. 2 edges accept-to-consume minimum).
- Throughput: one request per cycle with out_ready held high.
- Backpressure: out_ready low with out_valid=1 and s1_valid=1 → in_ready=0; both stages hold values stable; no drop, no duplication, order preserved.
- Simultaneous consume and load: output stage takes new s1 result on same edge old one is consumed.
- Reset mid-operation: all in-flight requests discarded, no result emitted.
- out_data/out_err stable while out_valid && !out_ready.

## Test plan
- sll shamt=4, rt=0x000000F1 → out_data 0x00000F10, out_err 0, out_valid two edges after accept.
- sra shamt=8, rt=0x80000000 → 0xFF800000; srlv rs=0x23, rt=0xF0000000 → 0x1E000000 (amount 3).
- Back-to-back 4 requests, out_ready low for 3 cycles after first result → in_ready drops after two are held; all 4 results emerge in order, unchanged.
- funct=0x20 → out_data 0, out_err 1, err_cnt 0→1; 260 illegal requests → err_cnt stays 255.
- flush with both stages full → out_valid 0 next cycle, no results emitted, err_cnt unchanged; following request completes normally.
- rst_n low mid-stream (asynchronous, between edges) → all outputs at reset values immediately; no stale result after release.

Source files
------------

// File: rtl/shift_unit_ctrl_if.sv
// Request, shifter and result signals of shift_unit_ctrl bundled into one interface.
// The slave view belongs to the controller; the master view belongs to whatever drives it.
interface shift_unit_ctrl_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] sh_a;
    logic [4:0]  sh_b;
    logic [1:0]  sh_aluc;
    logic [31:0] sh_c;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic [7:0]  err_cnt;

    modport slave (
        input  flush, in_valid, funct, shamt, rs_data, rt_data, sh_c, out_ready,
        output in_ready, sh_a, sh_b, sh_aluc, out_valid, out_data, out_err, err_cnt
    );

    modport master (
        output flush, in_valid, funct, shamt, rs_data, rt_data, sh_c, out_ready,
        input  in_ready, sh_a, sh_b, sh_aluc, out_valid, out_data, out_err, err_cnt
    );
endinterface

// File: rtl/shift_unit_ctrl.sv
// Two-stage control wrapper for the execute-path barrel shifter: decode stage feeding the
// shifter from registers, then an output register holding the shifted result.
module shift_unit_ctrl (
    input  logic             clk,
    input  logic             rst_n,
    shift_unit_ctrl_if.slave bus
);
    localparam logic [1:0] ALUC_SRA = 2'b00;
    localparam logic [1:0] ALUC_SRL = 2'b01;
    localparam logic [1:0] ALUC_SLL = 2'b10;

    logic        r_s1_valid;
    logic [31:0] r_a;
    logic [4:0]  r_b;
    logic [1:0]  r_aluc;
    logic        r_err;

    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_out_err;
    logic [7:0]  r_err_cnt;

    logic [31:0] w_dec_a;
    logic [4:0]  w_dec_b;
    logic [1:0]  w_dec_aluc;
    logic        w_dec_err;
    logic        w_s2_free;
    logic        w_advance;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_rs_unused;

    assign w_rs_unused = ^bus.rs_data[31:5];

    always_comb begin
        w_dec_a    = bus.rt_data;
        w_dec_b    = bus.shamt;
        w_dec_aluc = ALUC_SRL;
        w_dec_err  = 1'b0;
        case (bus.funct)
            6'h00: w_dec_aluc = ALUC_SLL;
            6'h02: w_dec_aluc = ALUC_SRL;
            6'h03: w_dec_aluc = ALUC_SRA;
            6'h04: begin
                w_dec_aluc = ALUC_SLL;
                w_dec_b    = bus.rs_data[4:0];
            end
            6'h06: begin
                w_dec_aluc = ALUC_SRL;
                w_dec_b    = bus.rs_data[4:0];
            end
            6'h07: begin
                w_dec_aluc = ALUC_SRA;
                w_dec_b    = bus.rs_data[4:0];
            end
            default: begin
                // Illegal codes park the shifter on a harmless zero operation.
                w_dec_a    = '0;
                w_dec_b    = '0;
                w_dec_aluc = ALUC_SRL;
                w_dec_err  = 1'b1;
            end
        endcase
    end

    assign w_s2_free  = !r_out_valid || bus.out_ready;
    assign w_advance  = r_s1_valid && w_s2_free;
    assign w_in_ready = !bus.flush && (!r_s1_valid || w_s2_free);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_aluc      <= ALUC_SRL;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_err_cnt   <= '0;
        end else if (bus.flush) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_advance) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_err ? '0 : bus.sh_c;
                r_out_err   <= r_err;
                if (r_err && (r_err_cnt != 8'hFF)) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_a        <= w_dec_a;
                r_b        <= w_dec_b;
                r_aluc     <= w_dec_aluc;
                r_err      <= w_dec_err;
            end else if (w_advance) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.sh_a      = r_a;
    assign bus.sh_b      = r_b;
    assign bus.sh_aluc   = r_aluc;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_err   = r_out_err;
    assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_shift_unit_ctrl.sv
// Bench for shift_unit_ctrl: directed scenarios plus randomized traffic against a
// result-level scoreboard; the shifter itself is modelled behaviourally.
module tb_shift_unit_ctrl;
    logic clk;
    logic rst_n;
    shift_unit_ctrl_if bus ();

    shift_unit_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [31:0] sh_a_s;
    assign sh_a_s     = bus.sh_a;
    assign bus.sh_c   = (bus.sh_aluc == 2'b10) ? (bus.sh_a << bus.sh_b) :
                        (bus.sh_aluc == 2'b01) ? (bus.sh_a >> bus.sh_b) :
                        32'(sh_a_s >>> bus.sh_b);

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          counted;
    } item_t;

    item_t q[$];
    bit    acc_last;
    int    ecnt;
    int    checks;
    int    errors;
    int    saved_cnt;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    function automatic item_t ref_item(input logic [5:0] f, input logic [4:0] sa,
                                       input logic [31:0] rs, input logic [31:0] rt);
        item_t it;
        logic signed [31:0] srt;
        srt        = rt;
        it.err     = 1'b0;
        it.counted = 1'b0;
        case (f)
            6'h00:   it.data = rt << sa;
            6'h02:   it.data = rt >> sa;
            6'h03:   it.data = 32'(srt >>> sa);
            6'h04:   it.data = rt << rs[4:0];
            6'h06:   it.data = rt >> rs[4:0];
            6'h07:   it.data = 32'(srt >>> rs[4:0]);
            default: begin
                it.data = '0;
                it.err  = 1'b1;
            end
        endcase
        return it;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic [5:0] f, input logic [4:0] sa,
                           input logic [31:0] rs, input logic [31:0] rt);
        bus.in_valid = v;
        bus.funct    = f;
        bus.shamt    = sa;
        bus.rs_data  = rs;
        bus.rt_data  = rt;
    endtask

    // One clock: compare against the scoreboard at the falling edge, then advance the model.
    task automatic cycle();
        bit    exp_ov;
        bit    exp_ir;
        bit    acc;
        bit    cons;
        item_t nxt;
        @(negedge clk);
        exp_ov = (q.size() == 2) || (q.size() == 1 && !acc_last);
        exp_ir = !bus.flush && (q.size() < 2 || bus.out_ready);
        if (exp_ov && !q[0].counted) begin
            q[0].counted = 1'b1;
            if (q[0].err) ecnt++;
        end
        check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        check("in_ready", 32'(bus.in_ready), 32'(exp_ir));
        check("err_cnt", 32'(bus.err_cnt), (ecnt > 255) ? 32'd255 : 32'(ecnt));
        if (exp_ov) begin
            check("out_data", bus.out_data, q[0].data);
            check("out_err", 32'(bus.out_err), 32'(q[0].err));
        end
        acc  = bus.in_valid && exp_ir;
        cons = exp_ov && bus.out_ready;
        nxt  = ref_item(bus.funct, bus.shamt, bus.rs_data, bus.rt_data);
        @(posedge clk);
        #1;
        if (bus.flush) begin
            q.delete();
            acc_last = 1'b0;
        end else begin
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(nxt);
            acc_last = acc;
        end
        $display("cycle t=%0t acc=%0d cons=%0d flush=%0d depth=%0d", $time, acc, cons, bus.flush, q.size());
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_data"}, bus.out_data, 32'd0);
        check({tag, "_out_err"}, 32'(bus.out_err), 32'd0);
        check({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'd0);
        check({tag, "_sh_a"}, bus.sh_a, 32'd0);
        check({tag, "_sh_b"}, 32'(bus.sh_b), 32'd0);
        check({tag, "_sh_aluc"}, 32'(bus.sh_aluc), 32'd1);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        ecnt     = 0;
        acc_last = 1'b0;
        rst_n    = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        set_req(1'b0, 6'h00, 5'd0, 32'd0, 32'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // sll shamt=4 and its two-edge latency
        set_req(1'b1, 6'h00, 5'd4, 32'd0, 32'h0000_00F1);
        cycle();
        set_req(1'b0, 6'h00, 5'd0, 32'd0, 32'd0);
        check("sll_lat_early", 32'(bus.out_valid), 32'd0);
        cycle();
        check("sll_lat_valid", 32'(bus.out_valid), 32'd1);
        check("sll_data", bus.out_data, 32'h0000_0F10);
        check("sll_err", 32'(bus.out_err), 32'd0);
        bus.out_ready = 1'b1;
        cycle();

        // sra and srlv
        set_req(1'b1, 6'h03, 5'd8, 32'd0, 32'h8000_0000);
        cycle();
        set_req(1'b1, 6'h06, 5'd0, 32'h0000_0023, 32'hF000_0000);
        cycle();
        check("sra_data", bus.out_data, 32'hFF80_0000);
        set_req(1'b0, 6'h00, 5'd0, 32'd0, 32'd0);
        cycle();
        check("srlv_data", bus.out_data, 32'h1E00_0000);
        cycle();

        // Illegal funct
        set_req(1'b1, 6'h20, 5'd3, 32'd5, 32'hDEAD_BEEF);
        cycle();
        set_req(1'b0, 6'h00, 5'd0, 32'd0, 32'd0);
        cycle();
        check("ill_data", bus.out_data, 32'd0);
        check("ill_err", 32'(bus.out_err), 32'd1);
        check("ill_cnt", 32'(bus.err_cnt), 32'd1);
        cycle();

        // Backpressure: four requests, sink stalled three cycles after the first result
        bus.out_ready = 1'b0;
        set_req(1'b1, 6'h00, 5'd1, 32'd0, 32'h0000_0011);
        cycle();
        set_req(1'b1, 6'h02, 5'd2, 32'd0, 32'h0000_0F00);
        cycle();
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        set_req(1'b1, 6'h07, 5'd0, 32'd4, 32'hF000_0000);
        cycle();
        cycle();
        check("bp_hold_data", bus.out_data, 32'h0000_0022);
        bus.out_ready = 1'b1;
        cycle();
        set_req(1'b1, 6'h04, 5'd0, 32'd31, 32'h0000_0001);
        cycle();
        set_req(1'b0, 6'h00, 5'd0, 32'd0, 32'd0);
        repeat (4) cycle();

        // Flush with both stages full
        bus.out_ready = 1'b0;
        set_req(1'b1, 6'h00, 5'd8, 32'd0, 32'h0000_00AB);
        cycle();
        set_req(1'b1, 6'h02, 5'd4, 32'd0, 32'h0000_AB00);
        cycle();
        saved_cnt = 32'(bus.err_cnt);
        set_req(1'b0, 6'h00, 5'd0, 32'd0, 32'd0);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_err_cnt", 32'(bus.err_cnt), 32'(saved_cnt));
        bus.out_ready = 1'b1;
        set_req(1'b1, 6'h03, 5'd31, 32'd0, 32'h8000_0000);
        cycle();
        set_req(1'b0, 6'h00, 5'd0, 32'd0, 32'd0);
        cycle();
        check("post_flush_data", bus.out_data, 32'hFFFF_FFFF);
        repeat (2) cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [5:0] f;
            case ($urandom_range(0, 7))
                0: f = 6'h00;
                1: f = 6'h02;
                2: f = 6'h03;
                3: f = 6'h04;
                4: f = 6'h06;
                5: f = 6'h07;
                default: f = 6'($urandom_range(0, 63));
            endcase
            set_req($urandom_range(0, 3) != 0, f, 5'($urandom), $urandom, $urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 39) == 0);
            cycle();
        end
        bus.flush = 1'b0;

        // Asynchronous reset with both stages occupied
        bus.out_ready = 1'b0;
        set_req(1'b1, 6'h00, 5'd3, 32'd0, 32'h0000_0007);
        cycle();
        cycle();
        set_req(1'b0, 6'h00, 5'd0, 32'd0, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        q.delete();
        acc_last = 1'b0;
        ecnt     = 0;
        @(posedge clk);
        #1;
        check_reset_values("arst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) cycle();

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            set_req(1'b1, 6'(6'h08 + 6'($urandom_range(0, 23))), 5'($urandom), $urandom, $urandom);
            cycle();
        end
        set_req(1'b0, 6'h00, 5'd0, 32'd0, 32'd0);
        repeat (3) cycle();
        check("sat_err_cnt", 32'(bus.err_cnt), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
